// File: rtl/time_set_ctrl.sv
// Button sequencer for the clock: RUN/SET_HOUR/SET_MIN mode, 1 Hz tick, adjust pulses with auto-repeat, blink.
// Latency: a button level acts 3 edges after its first sample, and every output is registered; there is no backpressure.
module time_set_ctrl #(
    parameter int TICK_CYCLES   = 50000000,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int BLINK_CYCLES  = 12500000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       set_btn,
    input  logic       hour_btn,
    input  logic       minute_btn,
    output logic [1:0] mode,
    output logic       sec_tick,
    output logic       inc_hour,
    output logic       inc_min,
    output logic       clr_sec,
    output logic       blank_hour,
    output logic       blank_min,
    output logic       LEDR
);
    localparam logic [1:0] RUN      = 2'b00;
    localparam logic [1:0] SET_HOUR = 2'b01;
    localparam logic [1:0] SET_MIN  = 2'b10;

    localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW   = (TICK_CYCLES  > 1) ? $clog2(TICK_CYCLES)  : 1;
    localparam int RW   = (RMAX         > 1) ? $clog2(RMAX)         : 1;
    localparam int BW   = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    // Button bit order: [0] set, [1] hour, [2] minute
    logic [2:0]    s1_q, s2_q, lvl_q, edge_q;
    logic [1:0]    mode_q, mode_d;
    logic          run_q;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_on_q, rep_on_d, rep_fast_q, rep_fast_d;
    logic [BW-1:0] blk_cnt_q, blk_cnt_d;
    logic          phase_q, phase_d;
    logic          sec_tick_q, inc_hour_q, inc_min_q, clr_sec_q;
    logic          blank_hour_q, blank_min_q, ledr_q;
    logic          set_ev, act_edge, act_lvl, rep_exp, fire, tick_en;

    assign set_ev   = edge_q[0];
    assign act_edge = ((mode_q == SET_HOUR) & edge_q[1]) | ((mode_q == SET_MIN) & edge_q[2]);
    assign act_lvl  = ((mode_q == SET_HOUR) & lvl_q[1])  | ((mode_q == SET_MIN) & lvl_q[2]);
    assign rep_exp  = rep_on_q & (rep_cnt_q == (rep_fast_q ? RW'(REPEAT_CYCLES - 1) : RW'(HOLD_CYCLES - 1)));
    // A set edge always wins over an adjust edge or a repeat expiry in the same cycle
    assign fire     = ~set_ev & act_lvl & (act_edge | rep_exp);

    always_comb begin
        mode_d = mode_q;
        if (set_ev) begin
            case (mode_q)
                RUN:      mode_d = SET_HOUR;
                SET_HOUR: mode_d = SET_MIN;
                default:  mode_d = RUN;
            endcase
        end
    end

    always_comb begin
        rep_on_d   = rep_on_q;
        rep_cnt_d  = rep_cnt_q;
        rep_fast_d = rep_fast_q;
        if (set_ev || !act_lvl) begin
            rep_on_d   = 1'b0;
            rep_cnt_d  = '0;
            rep_fast_d = 1'b0;
        end else if (fire) begin
            rep_on_d   = 1'b1;
            rep_cnt_d  = '0;
            rep_fast_d = ~act_edge;
        end else if (rep_on_q) begin
            rep_cnt_d  = rep_cnt_q + RW'(1);
        end
    end

    // run_q delays counting by one edge, so the first tick lands TICK_CYCLES edges after RUN starts
    always_comb begin
        tick_en    = run_q & (mode_q == RUN) & (mode_d == RUN);
        tick_cnt_d = '0;
        if (tick_en) begin
            tick_cnt_d = (tick_cnt_q == TW'(TICK_CYCLES - 1)) ? '0 : tick_cnt_q + TW'(1);
        end
    end

    always_comb begin
        blk_cnt_d = '0;
        phase_d   = 1'b0;
        if (mode_d != RUN && mode_d == mode_q) begin
            if (blk_cnt_q == BW'(BLINK_CYCLES - 1)) begin
                phase_d = ~phase_q;
            end else begin
                blk_cnt_d = blk_cnt_q + BW'(1);
                phase_d   = phase_q;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            s1_q         <= '0;
            s2_q         <= '0;
            lvl_q        <= '0;
            edge_q       <= '0;
            mode_q       <= RUN;
            run_q        <= 1'b0;
            tick_cnt_q   <= '0;
            rep_cnt_q    <= '0;
            rep_on_q     <= 1'b0;
            rep_fast_q   <= 1'b0;
            blk_cnt_q    <= '0;
            phase_q      <= 1'b0;
            sec_tick_q   <= 1'b0;
            inc_hour_q   <= 1'b0;
            inc_min_q    <= 1'b0;
            clr_sec_q    <= 1'b0;
            blank_hour_q <= 1'b0;
            blank_min_q  <= 1'b0;
            ledr_q       <= 1'b0;
        end else begin
            s1_q         <= {minute_btn, hour_btn, set_btn};
            s2_q         <= s1_q;
            lvl_q        <= s2_q;
            edge_q       <= s2_q & ~lvl_q;
            mode_q       <= mode_d;
            run_q        <= (mode_q == RUN);
            tick_cnt_q   <= tick_cnt_d;
            rep_cnt_q    <= rep_cnt_d;
            rep_on_q     <= rep_on_d;
            rep_fast_q   <= rep_fast_d;
            blk_cnt_q    <= blk_cnt_d;
            phase_q      <= phase_d;
            sec_tick_q   <= tick_en & (tick_cnt_d == TW'(TICK_CYCLES - 1));
            inc_hour_q   <= fire & (mode_q == SET_HOUR);
            inc_min_q    <= fire & (mode_q == SET_MIN);
            clr_sec_q    <= set_ev & (mode_q == RUN);
            blank_hour_q <= (mode_d == SET_HOUR) & phase_d;
            blank_min_q  <= (mode_d == SET_MIN) & phase_d;
            ledr_q       <= (mode_d != RUN);
        end
    end

    assign mode       = mode_q;
    assign sec_tick   = sec_tick_q;
    assign inc_hour   = inc_hour_q;
    assign inc_min    = inc_min_q;
    assign clr_sec    = clr_sec_q;
    assign blank_hour = blank_hour_q;
    assign blank_min  = blank_min_q;
    assign LEDR       = ledr_q;
endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Mode and sequencing controller for the 12/24-hour clock datapath.
- Turns raw set/hour/minute button levels into a RUN / SET_HOUR / SET_MIN mode.
- Generates a 1 Hz seconds-advance enable, single-cycle increment pulses with press-and-hold auto-repeat, a seconds clear, and display blink controls.
- Sits between the board buttons and the time counters / binary_to_bcd / seven_seg display chain, replacing ad-hoc button handling.

Parameters:
TICK_CYCLES, 50000000, CLOCK_50 cycles per sec_tick in RUN (1 Hz)
HOLD_CYCLES, 25000000, cycles a button must stay held after its first pulse before auto-repeat starts
REPEAT_CYCLES, 5000000, cycles between auto-repeat pulses
BLINK_CYCLES, 12500000, cycles per blink phase in set modes

Ports:
CLOCK_50  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
set_btn  input  1  set/mode button, active-high, asynchronous to CLOCK_50, debounced externally
hour_btn  input  1  hour adjust button, active-high, asynchronous
minute_btn  input  1  minute adjust button, active-high, asynchronous
mode  output  2  00 RUN, 01 SET_HOUR, 10 SET_MIN (11 never driven)
sec_tick  output  1  one-cycle enable: advance seconds counter
inc_hour  output  1  one-cycle enable: increment hours
inc_min  output  1  one-cycle enable: increment minutes
clr_sec  output  1  one-cycle enable: clear seconds to 0
blank_hour  output  1  1 = blank hour digits (blink off-phase)
blank_min  output  1  1 = blank minute digits (blink off-phase)
LEDR  output  1  1 while in any set mode

Behaviour:
- Reset (reset=0, async):
  - mode=RUN.
  - All outputs 0.
  - Tick, repeat and blink counters = 0; blink phase = 0.
  - Synchronizer and edge-detect flops = 0.
- Input path:
  - Each button goes through a 2-flop synchronizer, then a registered rising-edge detect.
  - A level first sampled at edge k produces its registered output pulse in the cycle after edge k+3 (fixed 3-edge latency).
  - A button held high through reset release counts as a rising edge.
- State transitions, on set_btn rising edge only:
  - RUN -> SET_HOUR
  - SET_HOUR -> SET_MIN
  - SET_MIN -> RUN
- Entering SET_HOUR: clr_sec=1 for exactly one cycle, coincident with mode changing to 01.
- sec_tick:
  - RUN: the tick counter counts 0..TICK_CYCLES-1 and wraps. sec_tick=1 in the cycle the counter equals TICK_CYCLES-1.
  - Set modes: the counter is held at 0 and sec_tick=0.
  - Returning to RUN: the first sec_tick comes exactly TICK_CYCLES cycles after the mode change.
- Adjust pulses:
  - SET_HOUR: a hour_btn edge gives one inc_hour pulse; minute_btn is ignored.
  - SET_MIN: a minute_btn edge gives one inc_min pulse; hour_btn is ignored.
  - RUN: both adjust buttons are ignored.
  - inc_hour and inc_min are never high in the same cycle.
- Auto-repeat (active button for the current mode, synchronized level still 1):
  - The repeat counter starts at the first pulse.
  - Next pulse after HOLD_CYCLES cycles, then every REPEAT_CYCLES cycles.
  - Synchronized release clears the counter immediately; no pulse in the release cycle.
- Simultaneous events:
  - A set_btn edge in the same cycle as an adjust edge or repeat expiry: the mode change wins, no inc pulse.
  - Any mode change clears the repeat counter.
- Blink:
  - The counter runs only in set modes and toggles phase every BLINK_CYCLES cycles.
  - Phase = 0 (digits visible) on every set-mode entry.
  - blank_hour = (mode==SET_HOUR) & phase.
  - blank_min = (mode==SET_MIN) & phase.
  - Both are 0 in RUN.
- LEDR = (mode != RUN), registered together with mode.
- All outputs are registered, glitch-free and synchronous to CLOCK_50.
- Reset asserted mid-pulse or mid-repeat: outputs drop to 0 asynchronously and the FSM restarts in RUN.

Test Plan:
(Bench uses TICK_CYCLES=10, HOLD_CYCLES=8, REPEAT_CYCLES=3, BLINK_CYCLES=4.)
1. Release reset, no buttons, 100 cycles -> mode=00, sec_tick pulses exactly every 10 cycles (10 pulses), inc_*/clr_sec/LEDR stay 0.
2. Pulse set_btn 5 cycles -> 3 edges after first sample: mode=01, LEDR=1, clr_sec high exactly 1 cycle, sec_tick=0 thereafter; blank_hour 0 for 4 cycles, 1 for 4, repeating; blank_min=0.
3. In SET_HOUR hold hour_btn 30 cycles -> inc_hour pulses at relative cycles 0, 8, 11, 14, 17, 20, 23, 26, 29 (9 pulses); inc_min never high; release -> no further pulses.
4. In SET_MIN assert minute_btn and set_btn on the same edge -> mode goes 10->00, zero inc_min pulses; first sec_tick exactly 10 cycles after the mode change.
5. In RUN press hour_btn and minute_btn for 20 cycles -> no inc pulses, mode stays 00, sec_tick cadence unchanged.
6. In SET_HOUR during auto-repeat, drive reset=0 mid-cycle -> all outputs 0 immediately (async); after release mode=00 and the first sec_tick comes 10 cycles later.
